// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback
// over a shared-memory datapath, with memory-ready timeout, sticky traps and retire count.
module mips_multicycle_control #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32,
    parameter int ALUOP_W     = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [31:0]        instr,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               PCWrite,
    output logic               IorD,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic [1:0]         RegDst,
    output logic [1:0]         MemToReg,
    output logic               RegWrite,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [ALUOP_W-1:0] ALUop,
    output logic [1:0]         PCSource,
    output logic [3:0]         state,
    output logic               trap,
    output logic [1:0]         cause,
    output logic [CNT_W-1:0]   instret
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,  S_FETCH  = 4'd1,  S_DECODE = 4'd2,  S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,  S_MEMWB  = 4'd5,  S_MEMWR  = 4'd6,  S_EXEC   = 4'd7,
        S_RWB    = 4'd8,  S_IMMEX  = 4'd9,  S_IMMWB  = 4'd10, S_BRANCH = 4'd11,
        S_JUMP   = 4'd12, S_TRAP   = 4'd13
    } state_t;

    localparam logic [ALUOP_W-1:0] ALU_ADD = ALUOP_W'(3'b010);
    localparam logic [ALUOP_W-1:0] ALU_SUB = ALUOP_W'(3'b110);
    localparam logic [ALUOP_W-1:0] ALU_AND = ALUOP_W'(3'b000);
    localparam logic [ALUOP_W-1:0] ALU_OR  = ALUOP_W'(3'b001);
    localparam logic [ALUOP_W-1:0] ALU_SLT = ALUOP_W'(3'b111);
    localparam logic [ALUOP_W-1:0] ALU_LUI = ALUOP_W'(3'b011);

    localparam logic [5:0] OP_SPECIAL = 6'b000000, OP_J    = 6'b000010, OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ     = 6'b000100, OP_BNE  = 6'b000101, OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU   = 6'b001001, OP_SLTIU = 6'b001011, OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_LUI     = 6'b001111, OP_LW   = 6'b100011, OP_SW    = 6'b101011;

    localparam logic [5:0] FN_JR  = 6'b001000, FN_SYSCALL = 6'b001100, FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010, FN_AND     = 6'b100100, FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [7:0] WAIT_LIMIT = 8'(MEM_TIMEOUT);

    state_t     st;
    logic [7:0] wait_cnt;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       unused_fields;
    state_t     dec_state;
    logic [1:0] dec_cause;
    logic       mem_wait;
    logic       timeout;

    assign opcode        = instr[31:26];
    assign funct         = instr[5:0];
    assign unused_fields = ^instr[25:6];
    assign state         = st;

    // The access times out on the cycle whose wait would make the count reach the limit.
    assign mem_wait = (st == S_FETCH) || (st == S_MEMRD) || (st == S_MEMWR);
    assign timeout  = mem_wait && !mem_ready && ((wait_cnt + 8'd1) == WAIT_LIMIT);

    always_comb begin
        dec_state = S_TRAP;
        dec_cause = 2'b01;
        case (opcode)
            OP_SPECIAL: begin
                case (funct)
                    FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: dec_state = S_EXEC;
                    FN_JR:      dec_state = S_JUMP;
                    FN_SYSCALL: dec_cause = 2'b11;
                    default:    dec_cause = 2'b01;
                endcase
            end
            OP_ADDI, OP_ADDIU, OP_SLTIU, OP_ORI, OP_LUI: dec_state = S_IMMEX;
            OP_LW, OP_SW:   dec_state = S_MEMADR;
            OP_BEQ, OP_BNE: dec_state = S_BRANCH;
            OP_J, OP_JAL:   dec_state = S_JUMP;
            default:        dec_state = S_TRAP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st       <= S_IDLE;
            wait_cnt <= 8'd0;
            trap     <= 1'b0;
            cause    <= 2'b00;
            instret  <= '0;
        end else begin
            wait_cnt <= (mem_wait && !mem_ready) ? wait_cnt + 8'd1 : 8'd0;
            case (st)
                S_IDLE: st <= S_FETCH;
                S_FETCH: begin
                    if (mem_ready) st <= S_DECODE;
                    else if (timeout) begin
                        st <= S_TRAP; trap <= 1'b1; cause <= 2'b10;
                    end
                end
                S_DECODE: begin
                    st <= dec_state;
                    if (dec_state == S_TRAP) begin
                        trap  <= 1'b1;
                        cause <= dec_cause;
                    end
                end
                S_MEMADR: st <= (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
                S_MEMRD: begin
                    if (mem_ready) st <= S_MEMWB;
                    else if (timeout) begin
                        st <= S_TRAP; trap <= 1'b1; cause <= 2'b10;
                    end
                end
                S_MEMWR: begin
                    if (mem_ready) begin
                        st      <= S_FETCH;
                        instret <= instret + CNT_W'(1);
                    end else if (timeout) begin
                        st <= S_TRAP; trap <= 1'b1; cause <= 2'b10;
                    end
                end
                S_EXEC:  st <= S_RWB;
                S_IMMEX: st <= S_IMMWB;
                S_MEMWB, S_RWB, S_IMMWB, S_BRANCH, S_JUMP: begin
                    st      <= S_FETCH;
                    instret <= instret + CNT_W'(1);
                end
                S_TRAP:  st <= S_TRAP;
                default: st <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        PCWrite  = 1'b0;
        IorD     = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        IRWrite  = 1'b0;
        RegDst   = 2'b00;
        MemToReg = 2'b00;
        RegWrite = 1'b0;
        ALUSrcA  = 1'b0;
        ALUSrcB  = 2'b00;
        ALUop    = '0;
        PCSource = 2'b00;
        case (st)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                ALUop   = ALU_ADD;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
            end
            S_DECODE: begin
                ALUSrcB = 2'b10;
                ALUop   = ALU_ADD;
            end
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                ALUop   = ALU_ADD;
            end
            S_MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            S_MEMWB: begin
                RegWrite = 1'b1;
                MemToReg = 2'b01;
            end
            S_MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            S_EXEC: begin
                ALUSrcA = 1'b1;
                case (funct)
                    FN_SUB:  ALUop = ALU_SUB;
                    FN_AND:  ALUop = ALU_AND;
                    FN_OR:   ALUop = ALU_OR;
                    FN_SLT:  ALUop = ALU_SLT;
                    default: ALUop = ALU_ADD;
                endcase
            end
            S_RWB: begin
                RegWrite = 1'b1;
                RegDst   = 2'b01;
            end
            S_IMMEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = (opcode == OP_ORI) ? 2'b11 : 2'b10;
                case (opcode)
                    OP_ORI:   ALUop = ALU_OR;
                    OP_SLTIU: ALUop = ALU_SLT;
                    OP_LUI:   ALUop = ALU_LUI;
                    default:  ALUop = ALU_ADD;
                endcase
            end
            S_IMMWB: RegWrite = 1'b1;
            S_BRANCH: begin
                ALUSrcA  = 1'b1;
                ALUop    = ALU_SUB;
                PCSource = 2'b01;
                PCWrite  = (opcode == OP_BEQ) ? zero : !zero;
            end
            S_JUMP: begin
                PCWrite  = 1'b1;
                PCSource = (opcode == OP_SPECIAL) ? 2'b11 : 2'b10;
                if (opcode == OP_JAL) begin
                    RegWrite = 1'b1;
                    RegDst   = 2'b10;
                    MemToReg = 2'b10;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Directed bench for mips_multicycle_control: walks each instruction class through
// the FSM and compares state, control bundle, trap/cause and instret against constants.
module tb_mips_multicycle_control;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] instr = 32'd0;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b1;
    logic        PCWrite, IorD, MemRead, MemWrite, IRWrite, RegWrite, ALUSrcA;
    logic [1:0]  RegDst, MemToReg, ALUSrcB, PCSource, cause;
    logic [2:0]  ALUop;
    logic [3:0]  state;
    logic        trap;
    logic [31:0] instret;

    int checks = 0;
    int errors = 0;

    mips_multicycle_control #(.MEM_TIMEOUT(4), .CNT_W(32), .ALUOP_W(3)) dut (
        .clk(clk), .reset(reset), .instr(instr), .zero(zero), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .RegDst(RegDst), .MemToReg(MemToReg), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUop(ALUop), .PCSource(PCSource),
        .state(state), .trap(trap), .cause(cause), .instret(instret)
    );

    always #5 clk = ~clk;

    // {PCWrite,IorD,MemRead,MemWrite,IRWrite,RegDst,MemToReg,RegWrite,ALUSrcA,ALUSrcB,ALUop,PCSource}
    logic [17:0] ctl;
    assign ctl = {PCWrite, IorD, MemRead, MemWrite, IRWrite, RegDst, MemToReg,
                  RegWrite, ALUSrcA, ALUSrcB, ALUop, PCSource};

    localparam logic [17:0] C_ZERO     = 18'b0_0_0_0_0_00_00_0_0_00_000_00;
    localparam logic [17:0] C_FETCH_RD = 18'b1_0_1_0_1_00_00_0_0_01_010_00;
    localparam logic [17:0] C_FETCH_WT = 18'b0_0_1_0_0_00_00_0_0_01_010_00;
    localparam logic [17:0] C_DECODE   = 18'b0_0_0_0_0_00_00_0_0_10_010_00;
    localparam logic [17:0] C_EXEC_ADD = 18'b0_0_0_0_0_00_00_0_1_00_010_00;
    localparam logic [17:0] C_RWB      = 18'b0_0_0_0_0_01_00_1_0_00_000_00;
    localparam logic [17:0] C_MEMADR   = 18'b0_0_0_0_0_00_00_0_1_10_010_00;
    localparam logic [17:0] C_MEMRD    = 18'b0_1_1_0_0_00_00_0_0_00_000_00;
    localparam logic [17:0] C_MEMWB    = 18'b0_0_0_0_0_00_01_1_0_00_000_00;
    localparam logic [17:0] C_MEMWR    = 18'b0_1_0_1_0_00_00_0_0_00_000_00;
    localparam logic [17:0] C_BR_TAKEN = 18'b1_0_0_0_0_00_00_0_1_00_110_01;
    localparam logic [17:0] C_BR_NOT   = 18'b0_0_0_0_0_00_00_0_1_00_110_01;
    localparam logic [17:0] C_JAL      = 18'b1_0_0_0_0_10_10_1_0_00_000_10;
    localparam logic [17:0] C_JR       = 18'b1_0_0_0_0_00_00_0_0_00_000_11;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        #1;
        checks++;
        if ({state, ctl, trap, cause, instret} !== {4'd0, C_ZERO, 1'b0, 2'b00, 32'd0}) begin
            errors++;
            $display("FAIL reset state=%0d ctl=%b trap=%b cause=%0d instret=%0d, required 0/0/0/0/0",
                     state, ctl, trap, cause, instret);
        end
    endtask

    task automatic test_add();
        logic [3:0]  exp_st  [6] = '{4'd0, 4'd1, 4'd2, 4'd7, 4'd8, 4'd1};
        logic [17:0] exp_ctl [6] = '{C_ZERO, C_FETCH_RD, C_DECODE, C_EXEC_ADD, C_RWB, C_FETCH_RD};
        instr = 32'h012A4020;
        mem_ready = 1'b1;
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            #1;
            checks++;
            if (state !== exp_st[i] || ctl !== exp_ctl[i]) begin
                errors++;
                $display("FAIL add_step%0d state=%0d ctl=%b, required %0d %b", i, state, ctl, exp_st[i], exp_ctl[i]);
            end
            if (i < 5) tick();
        end
        checks++;
        if (instret !== 32'd1) begin
            errors++;
            $display("FAIL add_instret got %0d required 1", instret);
        end
    endtask

    task automatic test_lw_wait();
        instr = 32'h8D090004;
        apply_reset();
        tick();
        for (int i = 0; i < 4; i++) begin
            mem_ready = (i == 3);
            #1;
            checks++;
            if (state !== 4'd1 || ctl !== ((i == 3) ? C_FETCH_RD : C_FETCH_WT)) begin
                errors++;
                $display("FAIL lw_fetch%0d state=%0d ctl=%b, required 1", i, state, ctl);
            end
            tick();
        end
        tick();
        #1;
        checks++;
        if (state !== 4'd3 || ctl !== C_MEMADR) begin
            errors++;
            $display("FAIL lw_memadr state=%0d ctl=%b, required 3 %b", state, ctl, C_MEMADR);
        end
        tick();
        for (int i = 0; i < 3; i++) begin
            mem_ready = (i == 2);
            #1;
            checks++;
            if (state !== 4'd4 || ctl !== C_MEMRD) begin
                errors++;
                $display("FAIL lw_memrd%0d state=%0d ctl=%b, required 4 %b", i, state, ctl, C_MEMRD);
            end
            tick();
        end
        #1;
        checks++;
        if (state !== 4'd5 || ctl !== C_MEMWB || instret !== 32'd0) begin
            errors++;
            $display("FAIL lw_memwb state=%0d ctl=%b instret=%0d, required 5 %b 0", state, ctl, instret, C_MEMWB);
        end
        tick();
        checks++;
        if (state !== 4'd1 || instret !== 32'd1) begin
            errors++;
            $display("FAIL lw_retire state=%0d instret=%0d, required 1 1", state, instret);
        end
    endtask

    task automatic test_back_to_back_beq();
        instr = 32'h11090003;
        mem_ready = 1'b1;
        apply_reset();
        tick();
        for (int k = 0; k < 2; k++) begin
            tick();
            tick();
            zero = (k == 0);
            #1;
            checks++;
            if (state !== 4'd11 || ctl !== ((k == 0) ? C_BR_TAKEN : C_BR_NOT)) begin
                errors++;
                $display("FAIL beq_zero%0d state=%0d ctl=%b, required 11", 1 - k, state, ctl);
            end
            tick();
            checks++;
            if (state !== 4'd1 || instret !== 32'(k + 1)) begin
                errors++;
                $display("FAIL beq_retire%0d state=%0d instret=%0d, required 1 %0d", k, state, instret, k + 1);
            end
        end
        zero = 1'b0;
    endtask

    task automatic test_jal_jr();
        instr = 32'h0C000010;
        apply_reset();
        tick();
        tick();
        tick();
        #1;
        checks++;
        if (state !== 4'd12 || ctl !== C_JAL) begin
            errors++;
            $display("FAIL jal state=%0d ctl=%b, required 12 %b", state, ctl, C_JAL);
        end
        tick();
        instr = 32'h03E00008;
        tick();
        tick();
        #1;
        checks++;
        if (state !== 4'd12 || ctl !== C_JR) begin
            errors++;
            $display("FAIL jr state=%0d ctl=%b, required 12 %b", state, ctl, C_JR);
        end
        tick();
        checks++;
        if (instret !== 32'd2) begin
            errors++;
            $display("FAIL jump_instret got %0d required 2", instret);
        end
    endtask

    task automatic test_sw_timeout();
        instr = 32'hAD090004;
        mem_ready = 1'b1;
        apply_reset();
        tick();
        tick();
        tick();
        mem_ready = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (state !== 4'd6 || ctl !== C_MEMWR) begin
                errors++;
                $display("FAIL sw_memwr%0d state=%0d ctl=%b, required 6 %b", i, state, ctl, C_MEMWR);
            end
            tick();
        end
        mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if ({state, ctl, trap, cause, instret} !== {4'd13, C_ZERO, 1'b1, 2'b10, 32'd0}) begin
                errors++;
                $display("FAIL sw_trap%0d state=%0d ctl=%b trap=%b cause=%0d instret=%0d, required 13 0 1 2 0",
                         i, state, ctl, trap, cause, instret);
            end
            tick();
        end
        apply_reset();
        #1;
        checks++;
        if (state !== 4'd0 || trap !== 1'b0 || cause !== 2'b00) begin
            errors++;
            $display("FAIL trap_reset state=%0d trap=%b cause=%0d, required 0 0 0", state, trap, cause);
        end
    endtask

    task automatic test_decode_traps();
        logic [31:0] ins [2] = '{32'hFC000000, 32'h0000000C};
        logic [1:0]  cs  [2] = '{2'b01, 2'b11};
        mem_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            instr = ins[k];
            apply_reset();
            tick();
            tick();
            tick();
            #1;
            checks++;
            if (state !== 4'd13 || trap !== 1'b1 || cause !== cs[k] || ctl !== C_ZERO) begin
                errors++;
                $display("FAIL dec_trap%0d state=%0d trap=%b cause=%0d ctl=%b, required 13 1 %0d", k, state, trap, cause, ctl, cs[k]);
            end
        end
    endtask

    task automatic test_reset_mid_access();
        instr = 32'h8D090004;
        mem_ready = 1'b1;
        apply_reset();
        tick();
        tick();
        tick();
        mem_ready = 1'b0;
        tick();
        #1;
        checks++;
        if (state !== 4'd4) begin
            errors++;
            $display("FAIL mid_memrd state=%0d required 4", state);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        checks++;
        if (state !== 4'd0 || ctl !== C_ZERO) begin
            errors++;
            $display("FAIL mid_reset state=%0d ctl=%b, required 0 0", state, ctl);
        end
        mem_ready = 1'b1;
    endtask

    initial begin
        test_reset();
        test_add();
        test_lw_wait();
        test_back_to_back_beq();
        test_jal_jr();
        test_sw_timeout();
        test_decode_traps();
        test_reset_mid_access();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired after 100000 time units");
        $fatal(1);
    end

endmodule
